trigger_network_sync: RTL and testbench

//  Network-level counterpart to the per-actor trigger FSMs: collects sleep/sync_sleep/waited from
//  NUM_TRIGGERS triggers and returns registered all_sleep/all_sync_sleep/all_waited consensus flags.

---
 rtl/trigger_network_sync_pkg.sv | 12 +
 rtl/trigger_network_sync_flag_reduce.sv | 29 ++
 rtl/trigger_network_sync.sv | 105 ++++++++++
 tb/tb_trigger_network_sync.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/trigger_network_sync_pkg.sv
// Shared types for the trigger network synchroniser.
// This file holds the network FSM state encoding.
package trigger_network_sync_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } net_sync_state_e;

endpackage

// File: rtl/trigger_network_sync_flag_reduce.sv
// Registered AND-reduce of one per-trigger flag vector.
// The flop has an asynchronous, active-high reset.
module trigger_flag_reduce #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] flags,
    output logic         all_flag
);

    logic all_q;
    logic all_d;

    always_comb begin
        all_d = &flags;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            all_q <= 1'b0;
        end else begin
            all_q <= all_d;
        end
    end

    assign all_flag = all_q;

endmodule

// File: rtl/trigger_network_sync.sv
// Network-level start/done handshake and consensus flags for a set of trigger FSMs.
// Each trigger is launched once per invocation; sync barriers are counted while running.
module trigger_network_sync
    import trigger_network_sync_pkg::*;
#(
    parameter int NUM_TRIGGERS = 4,
    parameter int ROUND_W      = 32
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst,
    input  logic                    ap_start,
    output logic                    ap_done,
    output logic                    ap_idle,
    output logic                    ap_ready,
    input  logic [NUM_TRIGGERS-1:0] trig_sleep,
    input  logic [NUM_TRIGGERS-1:0] trig_sync_sleep,
    input  logic [NUM_TRIGGERS-1:0] trig_waited,
    input  logic [NUM_TRIGGERS-1:0] trig_idle,
    output logic [NUM_TRIGGERS-1:0] trig_start,
    output logic                    all_sleep,
    output logic                    all_sync_sleep,
    output logic                    all_waited,
    output logic [ROUND_W-1:0]      sync_rounds,
    output logic [1:0]              dbg_state
);

    net_sync_state_e         state_q, state_d;
    logic [NUM_TRIGGERS-1:0] launched_q, launched_d;
    logic [ROUND_W-1:0]      sync_rounds_q, sync_rounds_d;
    logic                    sync_prev_q, sync_prev_d;
    logic                    sync_edge;

    trigger_flag_reduce #(.N(NUM_TRIGGERS)) u_reduce_sleep (
        .clk(ap_clk), .rst(ap_rst), .flags(trig_sleep), .all_flag(all_sleep)
    );
    trigger_flag_reduce #(.N(NUM_TRIGGERS)) u_reduce_sync_sleep (
        .clk(ap_clk), .rst(ap_rst), .flags(trig_sync_sleep), .all_flag(all_sync_sleep)
    );
    trigger_flag_reduce #(.N(NUM_TRIGGERS)) u_reduce_waited (
        .clk(ap_clk), .rst(ap_rst), .flags(trig_waited), .all_flag(all_waited)
    );

    // Rising edge of the registered consensus marks one completed sync barrier.
    assign sync_edge   = all_sync_sleep & ~sync_prev_q;
    assign sync_prev_d = all_sync_sleep;

    always_comb begin
        state_d       = state_q;
        launched_d    = launched_q;
        sync_rounds_d = sync_rounds_q;
        trig_start    = '0;
        case (state_q)
            S_IDLE: begin
                if (ap_start) begin
                    state_d       = S_START;
                    launched_d    = '0;
                    sync_rounds_d = '0;
                end
            end
            S_START: begin
                // Once a trigger has left idle it stays launched, even if it finishes early.
                trig_start = ~launched_q;
                launched_d = launched_q | ~trig_idle;
                if (&launched_d) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (sync_edge && (sync_rounds_q != {ROUND_W{1'b1}})) begin
                    sync_rounds_d = sync_rounds_q + ROUND_W'(1);
                end
                if (&trig_idle) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q       <= S_IDLE;
            launched_q    <= '0;
            sync_rounds_q <= '0;
            sync_prev_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            launched_q    <= launched_d;
            sync_rounds_q <= sync_rounds_d;
            sync_prev_q   <= sync_prev_d;
        end
    end

    assign ap_idle     = (state_q == S_IDLE);
    assign ap_done     = (state_q == S_DONE);
    assign ap_ready    = ap_done;
    assign sync_rounds = sync_rounds_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_trigger_network_sync.sv
// Self-checking bench for trigger_network_sync: flag vector table plus handshake sequences.
// A second instance (one trigger, 2-bit counter) covers the degenerate width and saturation.
module tb_trigger_network_sync;

    logic       clk;
    logic       rst;

    logic       ap_start, ap_done, ap_idle, ap_ready;
    logic [3:0] trig_sleep, trig_sync_sleep, trig_waited, trig_idle, trig_start;
    logic       all_sleep, all_sync_sleep, all_waited;
    logic [31:0] sync_rounds;
    logic [1:0] dbg_state;

    logic       ap_start2, ap_done2, ap_idle2, ap_ready2;
    logic [0:0] sl2, ss2, wt2, idle2, trig_start2;
    logic       all_sl2, all_ss2, all_wt2;
    logic [1:0] rounds2;
    logic [1:0] state2;

    typedef struct {
        logic [3:0] sl;
        logic [3:0] ss;
        logic [3:0] wt;
        logic [2:0] exp;
    } vec_t;

    vec_t       vecs[14];
    logic [2:0] exp_q[$];
    int         n_vec;
    int         n_err;

    trigger_network_sync #(.NUM_TRIGGERS(4), .ROUND_W(32)) dut (
        .ap_clk(clk), .ap_rst(rst), .ap_start(ap_start), .ap_done(ap_done),
        .ap_idle(ap_idle), .ap_ready(ap_ready), .trig_sleep(trig_sleep),
        .trig_sync_sleep(trig_sync_sleep), .trig_waited(trig_waited),
        .trig_idle(trig_idle), .trig_start(trig_start), .all_sleep(all_sleep),
        .all_sync_sleep(all_sync_sleep), .all_waited(all_waited),
        .sync_rounds(sync_rounds), .dbg_state(dbg_state)
    );

    trigger_network_sync #(.NUM_TRIGGERS(1), .ROUND_W(2)) dut2 (
        .ap_clk(clk), .ap_rst(rst), .ap_start(ap_start2), .ap_done(ap_done2),
        .ap_idle(ap_idle2), .ap_ready(ap_ready2), .trig_sleep(sl2),
        .trig_sync_sleep(ss2), .trig_waited(wt2), .trig_idle(idle2),
        .trig_start(trig_start2), .all_sleep(all_sl2), .all_sync_sleep(all_ss2),
        .all_waited(all_wt2), .sync_rounds(rounds2), .dbg_state(state2)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_done_pulse(input string name);
        check({name, "_done"}, {31'd0, ap_done}, 32'd1);
        check({name, "_ready"}, {31'd0, ap_ready}, 32'd1);
        tick();
        check({name, "_done_clr"}, {31'd0, ap_done}, 32'd0);
        check({name, "_idle"}, {31'd0, ap_idle}, 32'd1);
    endtask

    task automatic sync_pulse();
        trig_sync_sleep = 4'hF;
        tick();
        trig_sync_sleep = 4'h0;
        tick();
        tick();
    endtask

    initial begin
        int d[4];
        logic [3:0] exp_start;
        logic [2:0] got;
        n_vec = 0;
        n_err = 0;

        vecs[0]  = '{4'h0, 4'h0, 4'h0, 3'b000};
        vecs[1]  = '{4'hF, 4'h0, 4'h0, 3'b100};
        vecs[2]  = '{4'hF, 4'h0, 4'h0, 3'b100};
        vecs[3]  = '{4'hF, 4'h0, 4'h0, 3'b100};
        vecs[4]  = '{4'hF, 4'h0, 4'h0, 3'b100};
        vecs[5]  = '{4'h7, 4'h0, 4'h0, 3'b000};
        vecs[6]  = '{4'h0, 4'hF, 4'h0, 3'b010};
        vecs[7]  = '{4'h0, 4'hF, 4'hF, 3'b011};
        vecs[8]  = '{4'h0, 4'hE, 4'hF, 3'b001};
        vecs[9]  = '{4'hF, 4'hF, 4'hF, 3'b111};
        vecs[10] = '{4'hF, 4'hF, 4'hB, 3'b110};
        vecs[11] = '{4'hD, 4'hF, 4'hF, 3'b011};
        vecs[12] = '{4'h0, 4'h0, 4'hF, 3'b001};
        vecs[13] = '{4'h0, 4'h0, 4'h0, 3'b000};

        // Reset with unknown trigger inputs
        rst = 1'b1;
        ap_start = 1'b0; ap_start2 = 1'b0;
        trig_sleep = 'x; trig_sync_sleep = 'x; trig_waited = 'x; trig_idle = 'x;
        sl2 = 'x; ss2 = 'x; wt2 = 'x; idle2 = 'x;
        tick();
        tick();
        check("rst_idle", {31'd0, ap_idle}, 32'd1);
        check("rst_done", {31'd0, ap_done}, 32'd0);
        check("rst_start", {28'd0, trig_start}, 32'd0);
        check("rst_flags", {29'd0, all_sleep, all_sync_sleep, all_waited}, 32'd0);
        check("rst_rounds", sync_rounds, 32'd0);
        check("rst_state", {30'd0, dbg_state}, 32'd0);
        trig_sleep = 4'h0; trig_sync_sleep = 4'h0; trig_waited = 4'h0; trig_idle = 4'hF;
        sl2 = 1'b0; ss2 = 1'b0; wt2 = 1'b0; idle2 = 1'b1;
        rst = 1'b0;
        tick();
        check("post_rst_idle", {31'd0, ap_idle}, 32'd1);

        // Consensus flags: one-cycle latency, scoreboarded
        for (int i = 0; i < 14; i++) begin
            trig_sleep = vecs[i].sl;
            trig_sync_sleep = vecs[i].ss;
            trig_waited = vecs[i].wt;
            exp_q.push_back(vecs[i].exp);
            #1;
            if (i > 0) begin
                check($sformatf("flag_hold[%0d]", i),
                      {29'd0, all_sleep, all_sync_sleep, all_waited}, {29'd0, vecs[i-1].exp});
            end
            tick();
            got = {all_sleep, all_sync_sleep, all_waited};
            check($sformatf("flag_vec[%0d]", i), {29'd0, got}, {29'd0, exp_q.pop_front()});
        end
        check("idle_no_count", sync_rounds, 32'd0);

        // Basic run: all triggers leave idle one cycle after start, three sync barriers
        ap_start = 1'b1;
        tick();
        ap_start = 1'b0;
        check("t1_state_start", {30'd0, dbg_state}, 32'd1);
        check("t1_start_c1", {28'd0, trig_start}, 32'hF);
        check("t1_not_idle", {31'd0, ap_idle}, 32'd0);
        tick();
        check("t1_start_c2", {28'd0, trig_start}, 32'hF);
        trig_idle = 4'h0;
        tick();
        check("t1_state_run", {30'd0, dbg_state}, 32'd2);
        check("t1_start_clr", {28'd0, trig_start}, 32'h0);
        sync_pulse();
        sync_pulse();
        sync_pulse();
        trig_idle = 4'hF;
        tick();
        check_done_pulse("t1");
        check("t1_rounds", sync_rounds, 32'd3);
        tick();
        check("t1_rounds_hold", sync_rounds, 32'd3);

        // Staggered launch; trigger 0 returns to idle early and must not be restarted
        d[0] = 1; d[1] = 3; d[2] = 5; d[3] = 7;
        ap_start = 1'b1;
        tick();
        ap_start = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            for (int i = 0; i < 4; i++) begin
                trig_idle[i] = (c >= d[i] + 1) ? 1'b0 : 1'b1;
                exp_start[i] = (c <= d[i] + 1) && (c <= 8);
            end
            if (c >= 4) trig_idle[0] = 1'b1;
            #1;
            check($sformatf("t2_start_c%0d", c), {28'd0, trig_start}, {28'd0, exp_start});
            check($sformatf("t2_state_c%0d", c), {30'd0, dbg_state}, (c <= 8) ? 32'd1 : 32'd2);
            tick();
        end
        trig_idle = 4'hF;
        tick();
        check_done_pulse("t2");
        check("t2_rounds_cleared", sync_rounds, 32'd0);

        // Minimum latency run with ap_start held through done
        ap_start = 1'b1;
        tick();
        trig_idle = 4'h0;
        tick();
        check("t6_run", {30'd0, dbg_state}, 32'd2);
        trig_idle = 4'hF;
        tick();
        check_done_pulse("t6");
        check("t6_idle_state", {30'd0, dbg_state}, 32'd0);
        tick();
        check("t6_restart", {30'd0, dbg_state}, 32'd1);
        check("t6_done_low", {31'd0, ap_done}, 32'd0);
        ap_start = 1'b0;
        trig_idle = 4'h0;
        tick();
        trig_idle = 4'hF;
        tick();
        check_done_pulse("t6b");

        // Asynchronous reset in S_START and in S_RUN
        ap_start = 1'b1;
        tick();
        ap_start = 1'b0;
        check("t5_start_hi", {28'd0, trig_start}, 32'hF);
        rst = 1'b1;
        #1;
        check("t5_start_rst", {28'd0, trig_start}, 32'h0);
        tick();
        rst = 1'b0;
        tick();
        ap_start = 1'b1;
        tick();
        ap_start = 1'b0;
        trig_idle = 4'h0;
        tick();
        trig_sleep = 4'hF; trig_sync_sleep = 4'hF; trig_waited = 4'hF;
        tick();
        tick();
        check("t5_flags_hi", {29'd0, all_sleep, all_sync_sleep, all_waited}, 32'h7);
        check("t5_rounds_one", sync_rounds, 32'd1);
        rst = 1'b1;
        #1;
        check("t5_flags_rst", {29'd0, all_sleep, all_sync_sleep, all_waited}, 32'h0);
        check("t5_rounds_rst", sync_rounds, 32'd0);
        check("t5_state_rst", {30'd0, dbg_state}, 32'd0);
        trig_sleep = 4'h0; trig_sync_sleep = 4'h0; trig_waited = 4'h0; trig_idle = 4'hF;
        tick();
        rst = 1'b0;
        tick();
        check("t5_idle_after", {31'd0, ap_idle}, 32'd1);
        check("t5_rounds_after", sync_rounds, 32'd0);

        // Single trigger, 2-bit counter: five barriers saturate at 3
        sl2 = 1'b1;
        tick();
        check("n1_all_sleep", {31'd0, all_sl2}, 32'd1);
        sl2 = 1'b0;
        ap_start2 = 1'b1;
        tick();
        ap_start2 = 1'b0;
        check("n1_start", {31'd0, trig_start2}, 32'd1);
        idle2 = 1'b0;
        tick();
        check("n1_run", {30'd0, state2}, 32'd2);
        for (int p = 0; p < 5; p++) begin
            ss2 = 1'b1;
            tick();
            ss2 = 1'b0;
            tick();
            tick();
        end
        check("n1_sat", {30'd0, rounds2}, 32'd3);
        idle2 = 1'b1;
        tick();
        check("n1_done", {31'd0, ap_done2}, 32'd1);
        check("n1_ready", {31'd0, ap_ready2}, 32'd1);
        tick();
        check("n1_idle", {31'd0, ap_idle2}, 32'd1);
        check("n1_rounds_hold", {30'd0, rounds2}, 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
